// File: rtl/rts_dcts_input_fifo.sv
// Receiving end of the RTS/DCTS router link: answers upstream DRTS with a
// one-cycle CTS pulse and queues accepted flits in a first-word fall-through FIFO.
module rts_dcts_input_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] RX,
    input  logic                  DRTS,
    input  logic                  read_en_N,
    input  logic                  read_en_E,
    input  logic                  read_en_W,
    input  logic                  read_en_S,
    input  logic                  read_en_L,
    output logic                  CTS,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  empty,
    output logic                  full,
    output logic [PTR_W:0]        count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic                  wr;
    logic                  rd;

    // Handshake: upstream holds DRTS with RX stable until it sees CTS; a flit
    // transfers at the edge where DRTS and CTS are both high, and CTS is only
    // raised when there is room, so that edge always has a free slot.
    assign wr = DRTS & CTS;
    // Multi-hot grants are tolerated and still pop a single entry.
    assign rd = (read_en_N | read_en_E | read_en_W | read_en_S | read_en_L) & ~empty;

    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign Data_out = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            CTS    <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            CTS <= DRTS & ~CTS & ~full;
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; a write coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (wr && !rst) begin
            mem[wr_ptr] <= RX;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(wr && full && !rd));

endmodule
